router_traffic_gen: RTL and testbench
=====================================

ROUTER_TRAFFIC_GEN -- requirements
Module: router_traffic_gen

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of AXI-stream channels.
REQ-002 SHALL have parameter PORT_WIDTH, default 128, tdata width per channel; minimum 40.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 300, idle cycles before abort.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: start  in  1  run request pulse; num_msgs  in  16  messages to send; dst_x  in  4; dst_y  in  4  destination stamped in every message.
REQ-006 SHALL have ports: tx_sel, rx_sel  in  $clog2(NUM_PORTS) each  generator/checker channel; throttle  in  1  rx backpressure mode.
REQ-007 SHALL have ports: tx_tvalid  out  NUM_PORTS; tx_tdata  out  NUM_PORTS*PORT_WIDTH; tx_tready  in  NUM_PORTS.
REQ-008 SHALL have ports: rx_tvalid  in  NUM_PORTS; rx_tdata  in  NUM_PORTS*PORT_WIDTH; rx_tready  out  NUM_PORTS.
REQ-009 SHALL have ports: busy, done, timeout  out  1 each; tx_count, rx_count, err_count  out  16 each.

Function
REQ-010 Message n SHALL be: [3:0]=dst_x, [7:4]=dst_y, [23:8]=n (16-bit seq, from 0), [PORT_WIDTH-1:24]=(n XOR 16'hA5A5) replicated, truncated at MSB.
REQ-011 FSM states SHALL be IDLE, RUN, DONE, TIMEOUT; reset state IDLE.
REQ-012 IDLE/DONE/TIMEOUT + start=1 SHALL go to RUN next cycle, clearing all counters, done, timeout and latching num_msgs, dst_x, dst_y, tx_sel, rx_sel, throttle.
REQ-013 start in RUN SHALL be ignored.
REQ-014 In RUN, tx_tvalid[tx_sel] SHALL assert with message tx_count; tvalid and tdata SHALL hold stable until tx_tready[tx_sel]=1; on handshake tx_count increments and next message presents next cycle (back-to-back allowed).
REQ-015 tx_tvalid SHALL deassert once tx_count==num_msgs; other channels' tx_tvalid/tx_tdata SHALL be 0.
REQ-016 rx_tready[rx_sel] SHALL be 1 in RUN when throttle=0; when throttle=1 it SHALL be 1 on alternate cycles, starting 1 the first RUN cycle; all other rx_tready bits SHALL be 0.
REQ-017 Each rx handshake SHALL increment rx_count and compare rx_tdata to message rx_count per REQ-010 with latched dst; any field mismatch increments err_count.
REQ-018 RUN SHALL go to DONE in the cycle after tx_count==num_msgs and rx_count==num_msgs both hold.
REQ-019 num_msgs=0 SHALL give RUN for exactly one cycle then DONE, no tx_tvalid.
REQ-020 Idle counter SHALL reset on any tx or rx handshake and on RUN entry; reaching TIMEOUT_CYCLES in RUN SHALL go to TIMEOUT.
REQ-021 err_count SHALL saturate at 16'hFFFF; tx/rx counters SHALL not exceed num_msgs.
REQ-022 rx beats arriving after rx_count==num_msgs while still RUN SHALL be accepted and increment err_count only.
REQ-023 busy SHALL equal (state==RUN); done SHALL be 1 in DONE and TIMEOUT; timeout SHALL be 1 in TIMEOUT only; both hold until next start.
REQ-024 tx handshake and rx handshake in the same cycle SHALL both be processed.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE and all outputs, counters and latched fields to 0, including mid-RUN.
REQ-026 Outputs SHALL become active no earlier than the first clk edge after rst_n rises.

Verification
REQ-027 Loopback tx_sel=1 to rx_sel=2, num_msgs=8, dst=(3,5), throttle=0 -> DONE, tx_count=8, rx_count=8, err_count=0, timeout=0.
REQ-028 Same with throttle=1 and tx_tready toggling randomly -> tvalid/tdata stable under stall, rx_count=8, err_count=0.
REQ-029 Loopback corrupting bit 100 of message 3 -> err_count=1, done=1.
REQ-030 tx_tready held 0, num_msgs=4 -> timeout=1 after 300 idle cycles, tx_count=0.
REQ-031 num_msgs=0 -> busy for 1 cycle, done=1, no tx_tvalid; start pulsed during RUN has no effect.
REQ-032 rst_n low mid-RUN after 3 messages -> all outputs 0 immediately; new start completes cleanly from seq 0.

Source files
------------

// File: rtl/router_traffic_gen.sv
// Router traffic generator/checker: streams num_msgs stamped messages on one
// AXI-stream channel and checks the same sequence arriving on another.
//
// Handshake rule: a beat transfers on a rising edge where tvalid and tready
// are both 1; the sender holds tvalid and tdata unchanged until that edge.
module router_traffic_gen #(
  parameter int NUM_PORTS      = 5,
  parameter int PORT_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 300,
  localparam int SEL_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [15:0]                     num_msgs,
  input  logic [3:0]                      dst_x,
  input  logic [3:0]                      dst_y,
  input  logic [SEL_W-1:0]                tx_sel,
  input  logic [SEL_W-1:0]                rx_sel,
  input  logic                            throttle,
  output logic [NUM_PORTS-1:0]            tx_tvalid,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] tx_tdata,
  input  logic [NUM_PORTS-1:0]            tx_tready,
  input  logic [NUM_PORTS-1:0]            rx_tvalid,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] rx_tdata,
  output logic [NUM_PORTS-1:0]            rx_tready,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout,
  output logic [15:0]                     tx_count,
  output logic [15:0]                     rx_count,
  output logic [15:0]                     err_count,
  output logic [1:0]                      dbg_state_o
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int REPS   = (PORT_WIDTH - 24 + 15) / 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t             state_q;
  logic [15:0]        num_q;
  logic [3:0]         dst_x_q;
  logic [3:0]         dst_y_q;
  logic [SEL_W-1:0]   tx_sel_q;
  logic [SEL_W-1:0]   rx_sel_q;
  logic               throttle_q;
  logic [15:0]        tx_cnt_q, tx_cnt_d;
  logic [15:0]        rx_cnt_q, rx_cnt_d;
  logic [15:0]        err_q, err_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               tx_valid_q;
  logic               rx_rdy_q;
  logic               busy_q;
  logic               done_q;
  logic               timeout_q;

  logic                  tx_ready_sel;
  logic                  rx_valid_sel;
  logic [PORT_WIDTH-1:0] rx_beat;
  logic [PORT_WIDTH-1:0] tx_msg;
  logic [PORT_WIDTH-1:0] rx_exp;
  logic                  tx_hs;
  logic                  rx_hs;
  logic                  rx_in_range;
  logic                  err_inc;
  logic                  all_done;
  logic                  idle_hit;

  // Payload above bit 24 is the seq XOR A5A5 pattern repeated, MSB copy truncated.
  function automatic logic [PORT_WIDTH-1:0] make_msg(input logic [15:0] seq,
                                                     input logic [3:0]  dx,
                                                     input logic [3:0]  dy);
    logic [REPS*16-1:0] rep;
    rep = {REPS{seq ^ 16'hA5A5}};
    return {rep[PORT_WIDTH-25:0], seq, dy, dx};
  endfunction

  always_comb begin
    tx_ready_sel = 1'b0;
    rx_valid_sel = 1'b0;
    rx_beat      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (tx_sel_q == SEL_W'(i)) begin
        tx_ready_sel = tx_tready[i];
      end
      if (rx_sel_q == SEL_W'(i)) begin
        rx_valid_sel = rx_tvalid[i];
        rx_beat      = rx_tdata[i*PORT_WIDTH +: PORT_WIDTH];
      end
    end
  end

  assign tx_msg      = make_msg(tx_cnt_q, dst_x_q, dst_y_q);
  assign rx_exp      = make_msg(rx_cnt_q, dst_x_q, dst_y_q);
  assign tx_hs       = tx_valid_q & tx_ready_sel;
  assign rx_hs       = rx_rdy_q & rx_valid_sel;
  assign rx_in_range = (rx_cnt_q < num_q);
  assign err_inc     = rx_hs & (~rx_in_range | (rx_beat != rx_exp));
  assign all_done    = (tx_cnt_q == num_q) && (rx_cnt_q == num_q);
  assign idle_hit    = ~(tx_hs | rx_hs) && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tx_cnt_d = tx_cnt_q + {15'd0, tx_hs};
    rx_cnt_d = rx_cnt_q + {15'd0, rx_hs & rx_in_range};
    err_d    = (err_inc && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
    idle_d   = (tx_hs | rx_hs) ? '0 : idle_q + IDLE_W'(1);
  end

  always_comb begin
    tx_tvalid = '0;
    tx_tdata  = '0;
    rx_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (tx_sel_q == SEL_W'(i)) begin
        tx_tvalid[i] = tx_valid_q;
        if (tx_valid_q) begin
          tx_tdata[i*PORT_WIDTH +: PORT_WIDTH] = tx_msg;
        end
      end
      if (rx_sel_q == SEL_W'(i)) begin
        rx_tready[i] = rx_rdy_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      tx_sel_q   <= '0;
      rx_sel_q   <= '0;
      throttle_q <= 1'b0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      err_q      <= '0;
      idle_q     <= '0;
      tx_valid_q <= 1'b0;
      rx_rdy_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          tx_cnt_q   <= tx_cnt_d;
          rx_cnt_q   <= rx_cnt_d;
          err_q      <= err_d;
          idle_q     <= idle_d;
          tx_valid_q <= (tx_cnt_d < num_q);
          rx_rdy_q   <= throttle_q ? ~rx_rdy_q : 1'b1;
          // Completion wins over a coincident idle expiry.
          if (all_done) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            tx_valid_q <= 1'b0;
            rx_rdy_q   <= 1'b0;
          end else if (idle_hit) begin
            state_q    <= S_TIMEOUT;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            tx_valid_q <= 1'b0;
            rx_rdy_q   <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            state_q    <= S_RUN;
            num_q      <= num_msgs;
            dst_x_q    <= dst_x;
            dst_y_q    <= dst_y;
            tx_sel_q   <= tx_sel;
            rx_sel_q   <= rx_sel;
            throttle_q <= throttle;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            err_q      <= '0;
            idle_q     <= '0;
            tx_valid_q <= (num_msgs != 16'd0);
            rx_rdy_q   <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign tx_count    = tx_cnt_q;
  assign rx_count    = rx_cnt_q;
  assign err_count   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_router_traffic_gen.sv
// Bench for router_traffic_gen: loopback/injection stimulus, a cycle-level
// behavioural model checked every cycle, and literal end-of-test expectations.
module tb_router_traffic_gen;

  localparam int NP = 5;
  localparam int PW = 128;
  localparam int TO = 300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic               start;
  logic [15:0]        num_msgs;
  logic [3:0]         dst_x, dst_y;
  logic [2:0]         tx_sel, rx_sel;
  logic               throttle;
  logic [NP-1:0]      tx_tvalid, tx_tready, rx_tvalid, rx_tready;
  logic [NP*PW-1:0]   tx_tdata, rx_tdata;
  logic               busy, done, timeout;
  logic [15:0]        tx_count, rx_count, err_count;
  logic [1:0]         dbg_state;

  router_traffic_gen #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_msgs(num_msgs),
    .dst_x(dst_x), .dst_y(dst_y), .tx_sel(tx_sel), .rx_sel(rx_sel),
    .throttle(throttle), .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata),
    .tx_tready(tx_tready), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
    .rx_tready(rx_tready), .busy(busy), .done(done), .timeout(timeout),
    .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] msg(input int n, input logic [3:0] x, input logic [3:0] y);
    logic [15:0]   s;
    logic [PW-1:0] m;
    s = 16'(n);
    m = PW'({s, y, x});
    for (int j = 0; 24 + 16*j < PW; j++) m = m | (PW'(s ^ 16'hA5A5) << (24 + 16*j));
    return m;
  endfunction

  // ---------------- loopback / injection wiring ----------------
  logic          lb_en = 1'b0, gate = 1'b0, gate_fix = 1'b0, gate_rand = 1'b0;
  logic          corrupt_on = 1'b0;
  logic [15:0]   corrupt_seq = 16'd0;
  logic          inj_valid = 1'b0;
  logic [PW-1:0] inj_word = '0;
  logic [PW-1:0] lb_word;

  always_comb begin
    lb_word   = '0;
    tx_tready = '0;
    rx_tvalid = '0;
    rx_tdata  = '0;
    if (lb_en) begin
      tx_tready[int'(tx_sel)] = rx_tready[int'(rx_sel)] & gate;
      rx_tvalid[int'(rx_sel)] = tx_tvalid[int'(tx_sel)] & gate;
      lb_word = tx_tdata[int'(tx_sel)*PW +: PW];
      if (corrupt_on && lb_word[23:8] == corrupt_seq) lb_word[100] = ~lb_word[100];
      rx_tdata[int'(rx_sel)*PW +: PW] = lb_word;
    end else if (inj_valid) begin
      rx_tvalid[int'(rx_sel)] = 1'b1;
      rx_tdata[int'(rx_sel)*PW +: PW] = inj_word;
    end
  end

  initial begin : gate_driver
    forever begin
      @(posedge clk);
      #1;
      gate = gate_rand ? 1'($urandom_range(0, 1)) : gate_fix;
    end
  end

  // ---------------- behavioural model + compare ----------------
  bit          m_run = 0, m_done = 0, m_to = 0, m_th = 0;
  int          m_tx = 0, m_rx = 0, m_err = 0, m_num = 0, m_idle = 0, m_rcyc = 0;
  int          m_tsel = 0, m_rsel = 0;
  logic [3:0]  m_x = '0, m_y = '0;
  int          busy_cyc = 0, tv_seen = 0;
  logic [PW-1:0] cap3 = '0;

  initial begin : compare
    bit            e_tv, e_rdy, thw, rhw, fin, prev_stall;
    logic [NP-1:0] ev, er, prev_tv;
    logic [PW-1:0] prev_data, rxw;
    prev_stall = 0;
    prev_tv    = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_run = 0; m_done = 0; m_to = 0; m_th = 0;
        m_tx = 0; m_rx = 0; m_err = 0; m_num = 0; m_idle = 0; m_rcyc = 0;
        m_tsel = 0; m_rsel = 0; m_x = '0; m_y = '0;
        prev_stall = 0;
      end else begin
        e_tv  = m_run && (m_tx < m_num);
        e_rdy = m_run && (!m_th || (m_rcyc % 2 == 0));
        ev = '0; er = '0;
        if (e_tv)  ev[m_tsel] = 1'b1;
        if (e_rdy) er[m_rsel] = 1'b1;
        chk("busy", PW'(busy), PW'(m_run));
        chk("done", PW'(done), PW'(m_done));
        chk("timeout", PW'(timeout), PW'(m_to));
        chk("tx_count", PW'(tx_count), PW'(m_tx));
        chk("rx_count", PW'(rx_count), PW'(m_rx));
        chk("err_count", PW'(err_count), PW'(m_err));
        chk("tx_tvalid", PW'(tx_tvalid), PW'(ev));
        chk("rx_tready", PW'(rx_tready), PW'(er));
        for (int i = 0; i < NP; i++) begin
          if (i != m_tsel) chk("tx_tdata_other", tx_tdata[i*PW +: PW], '0);
          else if (e_tv)   chk("tx_tdata", tx_tdata[i*PW +: PW], msg(m_tx, m_x, m_y));
        end
        if (prev_stall && m_run) begin
          chk("stall_tvalid", PW'(tx_tvalid), PW'(prev_tv));
          chk("stall_tdata", tx_tdata[m_tsel*PW +: PW], prev_data);
        end
        if (busy) busy_cyc++;
        if (|tx_tvalid) tv_seen++;

        thw = e_tv && tx_tready[m_tsel];
        rhw = e_rdy && rx_tvalid[m_rsel];
        prev_stall = e_tv && !tx_tready[m_tsel];
        prev_tv    = tx_tvalid;
        prev_data  = tx_tdata[m_tsel*PW +: PW];
        if (thw && m_tx == 3) cap3 = tx_tdata[m_tsel*PW +: PW];

        if (!m_run) begin
          if (start) begin
            m_run = 1; m_done = 0; m_to = 0;
            m_tx = 0; m_rx = 0; m_err = 0; m_idle = 0; m_rcyc = 0;
            m_num = int'(num_msgs); m_x = dst_x; m_y = dst_y;
            m_tsel = int'(tx_sel); m_rsel = int'(rx_sel); m_th = throttle;
          end
        end else begin
          fin = (m_tx == m_num) && (m_rx == m_num);
          if (rhw) begin
            rxw = rx_tdata[m_rsel*PW +: PW];
            if (m_rx < m_num) begin
              if (rxw != msg(m_rx, m_x, m_y) && m_err < 65535) m_err++;
              m_rx++;
            end else if (m_err < 65535) begin
              m_err++;
            end
          end
          if (thw) m_tx++;
          if (fin) begin
            m_run = 0; m_done = 1;
          end else if (!thw && !rhw && m_idle + 1 == TO) begin
            m_run = 0; m_done = 1; m_to = 1;
          end
          m_idle = (thw || rhw) ? 0 : m_idle + 1;
          m_rcyc++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic kick(input logic [15:0] n, input logic [3:0] x, input logic [3:0] y,
                      input logic [2:0] ts, input logic [2:0] rs, input logic th, input int hold);
    @(posedge clk);
    #1;
    num_msgs = n; dst_x = x; dst_y = y; tx_sel = ts; rx_sel = rs; throttle = th;
    busy_cyc = 0; tv_seen = 0;
    start = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    int c;
    c = 0;
    @(negedge clk);
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, PW'(done), PW'(1));
  endtask

  task automatic set_gate(input logic g, input logic r);
    gate_fix = g; gate_rand = r;
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, PW'(busy), '0);
    chk({tag, "_done"}, PW'(done), '0);
    chk({tag, "_timeout"}, PW'(timeout), '0);
    chk({tag, "_tx_count"}, PW'(tx_count), '0);
    chk({tag, "_rx_count"}, PW'(rx_count), '0);
    chk({tag, "_err_count"}, PW'(err_count), '0);
    chk({tag, "_tx_tvalid"}, PW'(tx_tvalid), '0);
    chk({tag, "_rx_tready"}, PW'(rx_tready), '0);
    chk({tag, "_tx_tdata_any"}, PW'(|tx_tdata), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int c;
    start = 0; num_msgs = 0; dst_x = 0; dst_y = 0; tx_sel = 0; rx_sel = 0; throttle = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    chk("model_msg3", msg(3, 4'd3, 4'd5), 128'hA6A5A6A5A6A5A6A5A6A5A6A5A6000353);
    chk("model_msg0", msg(0, 4'd0, 4'd0), 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5000000);

    // Plain loopback 1 -> 2; inputs changed after start and a start inside RUN.
    lb_en = 1'b1;
    set_gate(1'b1, 1'b0);
    kick(16'd8, 4'd3, 4'd5, 3'd1, 3'd2, 1'b0, 1);
    num_msgs = 16'd2; dst_x = 4'd0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_end(200, "t1_wait");
    chk("t1_tx_count", PW'(tx_count), PW'(8));
    chk("t1_rx_count", PW'(rx_count), PW'(8));
    chk("t1_err", PW'(err_count), PW'(0));
    chk("t1_timeout", PW'(timeout), PW'(0));
    chk("t1_msg3", cap3, 128'hA6A5A6A5A6A5A6A5A6A5A6A5A6000353);

    // Throttled receiver with random stalls.
    set_gate(1'b0, 1'b1);
    kick(16'd8, 4'd3, 4'd5, 3'd1, 3'd2, 1'b1, 1);
    wait_end(2000, "t2_wait");
    chk("t2_rx_count", PW'(rx_count), PW'(8));
    chk("t2_err", PW'(err_count), PW'(0));
    chk("t2_timeout", PW'(timeout), PW'(0));

    // Bit 100 of message 3 flipped in flight.
    set_gate(1'b1, 1'b0);
    corrupt_on = 1'b1; corrupt_seq = 16'd3;
    kick(16'd8, 4'd3, 4'd5, 3'd1, 3'd2, 1'b0, 1);
    wait_end(200, "t3_wait");
    corrupt_on = 1'b0;
    chk("t3_err", PW'(err_count), PW'(1));
    chk("t3_done", PW'(done), PW'(1));
    chk("t3_rx_count", PW'(rx_count), PW'(8));

    // Transmit side never ready: idle timeout.
    set_gate(1'b0, 1'b0);
    kick(16'd4, 4'd3, 4'd5, 3'd1, 3'd2, 1'b0, 1);
    wait_end(400, "t4_wait");
    chk("t4_timeout", PW'(timeout), PW'(1));
    chk("t4_tx_count", PW'(tx_count), PW'(0));
    chk("t4_busy_cycles", PW'(busy_cyc), PW'(TO));

    // Zero messages, start held into the RUN cycle.
    set_gate(1'b1, 1'b0);
    kick(16'd0, 4'd3, 4'd5, 3'd1, 3'd2, 1'b0, 2);
    wait_end(20, "t5_wait");
    repeat (3) @(negedge clk);
    chk("t5_busy_cycles", PW'(busy_cyc), PW'(1));
    chk("t5_done", PW'(done), PW'(1));
    chk("t5_timeout", PW'(timeout), PW'(0));
    chk("t5_tvalid_seen", PW'(tv_seen), PW'(0));

    // Direct rx injection: two good beats then three beyond num_msgs.
    lb_en = 1'b0;
    kick(16'd2, 4'd7, 4'd9, 3'd0, 3'd4, 1'b0, 1);
    for (int k = 0; k < 5; k++) begin
      inj_word = msg(k, 4'd7, 4'd9);
      inj_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    inj_valid = 1'b0;
    wait_end(400, "t6_wait");
    chk("t6_rx_count", PW'(rx_count), PW'(2));
    chk("t6_err", PW'(err_count), PW'(3));
    chk("t6_timeout", PW'(timeout), PW'(1));
    chk("t6_tx_count", PW'(tx_count), PW'(0));

    // Reset in the middle of a run, then a clean rerun.
    lb_en = 1'b1;
    set_gate(1'b1, 1'b0);
    kick(16'd8, 4'd3, 4'd5, 3'd1, 3'd2, 1'b0, 1);
    c = 0;
    while (tx_count != 16'd3 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t7_reach3", PW'(tx_count), PW'(3));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t7_async");
    @(negedge clk);
    #2 rst_n = 1'b1;
    kick(16'd8, 4'd3, 4'd5, 3'd1, 3'd2, 1'b0, 1);
    wait_end(200, "t7_wait");
    chk("t7_tx_count", PW'(tx_count), PW'(8));
    chk("t7_rx_count", PW'(rx_count), PW'(8));
    chk("t7_err", PW'(err_count), PW'(0));
    chk("t7_msg3", cap3, 128'hA6A5A6A5A6A5A6A5A6A5A6A5A6000353);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
